// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the datapath control sequencer.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/datapath_ctrl_imm_gen.sv
// Immediate generator: I-type or B-type sign extension chosen by opcode.
module imm_gen
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // Select the immediate format from the opcode field; unknown formats give zero.
  always_comb begin
    imm = 32'h0000_0000;
    case (instr[6:0])
      OP_IMM:    imm = {{20{instr[31]}}, instr[31:20]};
      OP_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default:   imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle control sequencer: fetches, decodes addi/bne/ecall and steers
// the register-file / ALU datapath. One EXEC cycle follows every fetch.
module datapath_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        eq,
  output logic [4:0]  ad1,
  output logic [4:0]  ad2,
  output logic [4:0]  ad3,
  output logic        we3,
  output logic [31:0] imm_op,
  output logic        alu_src,
  output logic        alu_ctrl,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] ir_r, ir_s;
  logic        halted_r, halted_s;
  logic        illegal_r, illegal_s;

  logic [31:0] imm_s;
  logic        is_halt_s, is_addi_s, is_bne_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  imm_gen u_imm_gen (
    .instr (ir_r),
    .imm   (imm_s)
  );

  // Classify the held instruction; the halt encoding takes priority over any decode.
  always_comb begin
    is_halt_s  = (ir_r == HALT_INSTR);
    is_addi_s  = !is_halt_s && (ir_r[6:0] == OP_IMM)    && (ir_r[14:12] == F3_ADDI);
    is_bne_s   = !is_halt_s && (ir_r[6:0] == OP_BRANCH) && (ir_r[14:12] == F3_BNE);
    pc_plus4_s = pc_r + 32'd4;
    target_s   = pc_r + imm_s;
  end

  // Datapath controls are live only during EXEC of a supported instruction.
  always_comb begin
    ad1      = 5'd0;
    ad2      = 5'd0;
    ad3      = 5'd0;
    we3      = 1'b0;
    imm_op   = 32'h0000_0000;
    alu_src  = 1'b0;
    alu_ctrl = ALU_ADD;
    if (state_r == ST_EXEC) begin
      if (is_addi_s) begin
        ad1     = ir_r[19:15];
        ad3     = ir_r[11:7];
        we3     = (ir_r[11:7] != 5'd0);
        imm_op  = imm_s;
        alu_src = 1'b1;
      end else if (is_bne_s) begin
        ad1      = ir_r[19:15];
        ad2      = ir_r[24:20];
        imm_op   = imm_s;
        alu_ctrl = ALU_SUB;
      end else begin
        we3 = 1'b0;
      end
    end else begin
      we3 = 1'b0;
    end
  end

  // Next-state, PC, IR and sticky status computation.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    ir_s      = ir_r;
    halted_s  = halted_r;
    illegal_s = illegal_r;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_s      = RESET_PC;
          halted_s  = 1'b0;
          illegal_s = 1'b0;
          state_s   = ST_FETCH;
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: begin
        if (imem_valid) begin
          ir_s    = imem_rdata;
          state_s = ST_EXEC;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (is_halt_s) begin
          halted_s = 1'b1;
          state_s  = ST_HALT;
        end else if (is_addi_s) begin
          pc_s    = pc_plus4_s;
          state_s = ST_FETCH;
        end else if (is_bne_s) begin
          if (eq) begin
            pc_s    = pc_plus4_s;
            state_s = ST_FETCH;
          end else if (target_s[1]) begin
            halted_s  = 1'b1;
            illegal_s = 1'b1;
            state_s   = ST_HALT;
          end else begin
            pc_s    = target_s;
            state_s = ST_FETCH;
          end
        end else begin
          halted_s  = 1'b1;
          illegal_s = 1'b1;
          state_s   = ST_HALT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Sequencer state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pc_r      <= RESET_PC;
      ir_r      <= 32'h0000_0000;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      ir_r      <= ir_s;
      halted_r  <= halted_s;
      illegal_r <= illegal_s;
    end
  end

  // Status and fetch interface derived directly from registered state.
  always_comb begin
    imem_req  = (state_r == ST_FETCH);
    imem_addr = pc_r;
    pc        = pc_r;
    busy      = (state_r == ST_FETCH) || (state_r == ST_EXEC);
    halted    = halted_r;
    illegal   = illegal_r;
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: expected EXEC-cycle controls are
// queued when an instruction is returned and compared when EXEC appears.
module tb_datapath_ctrl;

  typedef struct {
    logic [4:0]  ad1;
    logic [4:0]  ad2;
    logic [4:0]  ad3;
    logic        we3;
    logic [31:0] imm;
    logic        src;
    logic        ctrl;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        eq;
  logic [4:0]  ad1, ad2, ad3;
  logic        we3;
  logic [31:0] imm_op;
  logic        alu_src, alu_ctrl;
  logic [31:0] pc;
  logic        busy, halted, illegal;

  int checks_r = 0;
  int errors_r = 0;
  exp_t exp_q[$];

  datapath_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .eq         (eq),
    .ad1        (ad1),
    .ad2        (ad2),
    .ad3        (ad3),
    .we3        (we3),
    .imm_op     (imm_op),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_r++;
    if (got !== want) begin
      errors_r++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Monitor: an EXEC cycle is busy without a fetch request; pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && busy && !imem_req) begin
      if (exp_q.size() == 0) begin
        check("exec_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("exec_ad1",      {27'd0, ad1}, {27'd0, e.ad1});
        check("exec_ad2",      {27'd0, ad2}, {27'd0, e.ad2});
        check("exec_ad3",      {27'd0, ad3}, {27'd0, e.ad3});
        check("exec_we3",      {31'd0, we3}, {31'd0, e.we3});
        check("exec_imm",      imm_op,       e.imm);
        check("exec_alu_src",  {31'd0, alu_src},  {31'd0, e.src});
        check("exec_alu_ctrl", {31'd0, alu_ctrl}, {31'd0, e.ctrl});
      end
    end
  end

  function automatic exp_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                              input logic w, input logic [31:0] im, input logic s, input logic c);
    exp_t e;
    e.ad1 = a1; e.ad2 = a2; e.ad3 = a3; e.we3 = w; e.imm = im; e.src = s; e.ctrl = c;
    return e;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after EXEC completes.
  task automatic run_instr(input string tag, input logic [31:0] instr, input logic eqv, input int delay,
                           input exp_t e, input logic [31:0] exp_pc, input logic exp_halt, input logic exp_ill);
    int n;
    logic [31:0] addr0;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    addr0 = imem_addr;
    for (int i = 0; i < delay; i++) begin
      imem_valid = 1'b0;
      @(negedge clk);
      check({tag, "_stall_req"},  {31'd0, imem_req}, 32'd1);
      check({tag, "_stall_addr"}, imem_addr, addr0);
      check({tag, "_stall_we3"},  {31'd0, we3}, 32'd0);
      check({tag, "_stall_imm"},  imm_op, 32'd0);
    end
    imem_valid = 1'b1;
    imem_rdata = instr;
    eq         = eqv;
    exp_q.push_back(e);
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    check({tag, "_pc"},      pc, exp_pc);
    check({tag, "_halted"},  {31'd0, halted}, {31'd0, exp_halt});
    check({tag, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    check({tag, "_busy"},    {31'd0, busy}, {31'd0, !exp_halt});
  endtask

  initial begin
    exp_t z;
    z = mk(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_rdata = 32'd0; eq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'd0);
    check("rst_pc",    pc, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_halt",  {31'd0, halted}, 32'd0);
    check("rst_we3",   {31'd0, we3}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", {31'd0, imem_req}, 32'd0);

    pulse_start();
    // addi x1,x0,5 ; addi x0,x0,5
    run_instr("addi_x1", 32'h0050_0093, 1'b0, 0, mk(5'd0, 5'd0, 5'd1, 1'b1, 32'd5, 1'b1, 1'b0), 32'd4, 1'b0, 1'b0);
    run_instr("addi_x0", 32'h0050_0013, 1'b0, 0, mk(5'd0, 5'd0, 5'd0, 1'b0, 32'd5, 1'b1, 1'b0), 32'd8, 1'b0, 1'b0);
    // bne x1,x2,-4 taken then not taken
    run_instr("bne_tk",  32'hFE20_9EE3, 1'b0, 0, mk(5'd1, 5'd2, 5'd0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1), 32'd4, 1'b0, 1'b0);
    run_instr("addi_b",  32'h0050_0093, 1'b0, 0, mk(5'd0, 5'd0, 5'd1, 1'b1, 32'd5, 1'b1, 1'b0), 32'd8, 1'b0, 1'b0);
    run_instr("bne_nt",  32'hFE20_9EE3, 1'b1, 0, mk(5'd1, 5'd2, 5'd0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1), 32'd12, 1'b0, 1'b0);
    // addi x2,x1,-1 with a 5-cycle fetch stall
    run_instr("addi_stl", 32'hFFF0_8113, 1'b0, 5, mk(5'd1, 5'd0, 5'd2, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0), 32'd16, 1'b0, 1'b0);
    // bne x0,x1,+2 taken: misaligned target halts as illegal, pc held
    run_instr("bne_mis", 32'h0010_1163, 1'b0, 0, mk(5'd0, 5'd1, 5'd0, 1'b0, 32'd2, 1'b0, 1'b1), 32'd16, 1'b1, 1'b1);

    pulse_start();
    check("restart_addr", imem_addr, 32'd0);
    check("restart_ill",  {31'd0, illegal}, 32'd0);
    run_instr("ecall",   32'h0000_0073, 1'b0, 0, z, 32'd0, 1'b1, 1'b0);
    pulse_start();
    check("ecall_clr",   {31'd0, halted}, 32'd0);
    run_instr("bad",     32'hFFFF_FFFF, 1'b0, 0, z, 32'd0, 1'b1, 1'b1);
    pulse_start();
    check("bad_clr_h",   {31'd0, halted}, 32'd0);
    check("bad_clr_i",   {31'd0, illegal}, 32'd0);
    check("bad_req",     {31'd0, imem_req}, 32'd1);

    // Reset in the middle of an addi EXEC cycle
    imem_valid = 1'b1;
    imem_rdata = 32'h0050_0093;
    exp_q.push_back(mk(5'd0, 5'd0, 5'd1, 1'b1, 32'd5, 1'b1, 1'b0));
    @(negedge clk);
    imem_valid = 1'b0;
    #1;
    check("pre_rst_we3", {31'd0, we3}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we3",  {31'd0, we3}, 32'd0);
    check("mid_rst_pc",   pc, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_req",  {31'd0, imem_req}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end

endmodule
